// File: rtl/aes_pkg.sv
// Shared AES/Rijndael state-layout constants and byte/row index helpers used by
// the forward and inverse ShiftRows blocks.
package aes_pkg;

  localparam logic MODE_128 = 1'b0;
  localparam logic MODE_256 = 1'b1;

  localparam int unsigned NROWS  = 4;
  localparam int unsigned NB_128 = 4;
  localparam int unsigned NB_256 = 8;

  localparam int unsigned ROW_OFF_128 [NROWS] = '{0, 1, 2, 3};
  localparam int unsigned ROW_OFF_256 [NROWS] = '{0, 1, 3, 4};

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } skid_state_e;

  // Rows are contiguous words: byte (row, col) sits at row*nb + col.
  function automatic int unsigned byte_idx(input int unsigned row, input int unsigned col,
                                           input int unsigned nb);
    return row * nb + col;
  endfunction

  // Byte 0 is the most significant byte of an nbytes-wide field.
  function automatic int unsigned byte_lsb(input int unsigned idx, input int unsigned nbytes);
    return (nbytes - 1 - idx) * 8;
  endfunction

  function automatic int unsigned src_col(input int unsigned col, input int unsigned off,
                                          input int unsigned nb);
    return (col + off) % nb;
  endfunction

endpackage

// File: rtl/aes_shiftrow_perm.sv
// Combinational forward ShiftRows permutation for 128-bit AES and 256-bit
// Rijndael states; the unused upper half reads as zero in 128-bit mode.
module aes_shiftrow_perm
  import aes_pkg::*;
(
  input  logic         mode,
  input  logic [255:0] data_in,
  output logic [255:0] data_out
);

  logic [127:0] perm_128;
  logic [255:0] perm_256;

  for (genvar g = 0; g < 16; g++) begin : g_b128
    localparam int unsigned R   = g / NB_128;
    localparam int unsigned SRC = byte_idx(R, src_col(g % NB_128, ROW_OFF_128[R], NB_128), NB_128);
    assign perm_128[byte_lsb(g, 16) +: 8] = data_in[byte_lsb(SRC, 16) +: 8];
  end

  for (genvar g = 0; g < 32; g++) begin : g_b256
    localparam int unsigned R   = g / NB_256;
    localparam int unsigned SRC = byte_idx(R, src_col(g % NB_256, ROW_OFF_256[R], NB_256), NB_256);
    assign perm_256[byte_lsb(g, 32) +: 8] = data_in[byte_lsb(SRC, 32) +: 8];
  end

  always_comb begin
    data_out = '0;
    if (mode == MODE_256) data_out = perm_256;
    else                  data_out[127:0] = perm_128;
  end

endmodule

// File: rtl/aes_shiftrow_fwd.sv
// Streaming forward ShiftRows with a 2-entry skid buffer; data is permuted on
// acceptance so both entries hold already-shifted state.
module aes_shiftrow_fwd
  import aes_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [255:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [TAG_W-1:0] out_tag,
  output logic [255:0]     out_data,
  output logic [15:0]      blk_count
);

  skid_state_e      state_q, state_d;
  logic             m_mode_q, m_mode_d, s_mode_q, s_mode_d;
  logic [TAG_W-1:0] m_tag_q, m_tag_d, s_tag_q, s_tag_d;
  logic [255:0]     m_data_q, m_data_d, s_data_q, s_data_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [255:0]     perm_data;
  logic             in_xfer, out_xfer;

  aes_shiftrow_perm u_perm (
    .mode     (in_mode),
    .data_in  (in_data),
    .data_out (perm_data)
  );

  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_mode  = m_mode_q;
  assign out_tag   = m_tag_q;
  assign out_data  = m_data_q;
  assign blk_count = cnt_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    m_mode_d = m_mode_q;
    m_tag_d  = m_tag_q;
    m_data_d = m_data_q;
    s_mode_d = s_mode_q;
    s_tag_d  = s_tag_q;
    s_data_d = s_data_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          m_mode_d = in_mode;
          m_tag_d  = in_tag;
          m_data_d = perm_data;
          state_d  = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          m_mode_d = in_mode;
          m_tag_d  = in_tag;
          m_data_d = perm_data;
        end else if (in_xfer) begin
          s_mode_d = in_mode;
          s_tag_d  = in_tag;
          s_data_d = perm_data;
          state_d  = ST_TWO;
        end else if (out_xfer) begin
          state_d  = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_xfer) begin
          m_mode_d = s_mode_q;
          m_tag_d  = s_tag_q;
          m_data_d = s_data_q;
          state_d  = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (out_xfer && (cnt_q != '1)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      m_mode_q <= '0;
      m_tag_q  <= '0;
      m_data_q <= '0;
      s_mode_q <= '0;
      s_tag_q  <= '0;
      s_data_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      m_mode_q <= m_mode_d;
      m_tag_q  <= m_tag_d;
      m_data_q <= m_data_d;
      s_mode_q <= s_mode_d;
      s_tag_q  <= s_tag_d;
      s_data_q <= s_data_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_aes_shiftrow_fwd.sv
// Scoreboard bench for aes_shiftrow_fwd: a queue-based row-rotation model
// predicts each block and the matching inverse rotation must restore the input.
module tb_aes_shiftrow_fwd;

  localparam int TAG_W = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_mode = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [255:0]     in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_mode;
  logic [TAG_W-1:0] out_tag;
  logic [255:0]     out_data;
  logic [15:0]      blk_count;

  typedef struct {
    logic             mode;
    logic [TAG_W-1:0] tag;
    logic [255:0]     exp;
    logic [255:0]     orig;
  } item_t;

  item_t       sb[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
  logic [15:0] exp_cnt = '0;

  aes_shiftrow_fwd #(.TAG_W(TAG_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_tag   (out_tag),
    .out_data  (out_data),
    .blk_count (blk_count)
  );

  always #5 clock = ~clock;

  // Each row is rotated left (forward) or right (inverse) by its offset.
  function automatic logic [255:0] ref_shift(input logic mode, input logic [255:0] d,
                                             input bit inverse);
    int         nb;
    int         nbytes;
    int         off[4];
    logic [7:0] row[$];
    logic [255:0] r;
    r = '0;
    nb = mode ? 8 : 4;
    nbytes = 4 * nb;
    if (mode) off = '{0, 1, 3, 4};
    else      off = '{0, 1, 2, 3};
    for (int i = 0; i < 4; i++) begin
      row = {};
      for (int c = 0; c < nb; c++) row.push_back(d[(nbytes - 1 - (i * nb + c)) * 8 +: 8]);
      for (int k = 0; k < off[i]; k++) begin
        if (!inverse) row.push_back(row.pop_front());
        else          row.push_front(row.pop_back());
      end
      for (int c = 0; c < nb; c++) r[(nbytes - 1 - (i * nb + c)) * 8 +: 8] = row[c];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic m, input logic [TAG_W-1:0] t, input logic [255:0] d);
    item_t       it;
    int unsigned waited;
    waited = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_tag   = t;
    in_data  = d;
    while (!in_ready && waited < 500) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=%0b want 1", in_ready);
    end else begin
      it.mode = m;
      it.tag  = t;
      it.orig = m ? d : {128'b0, d[127:0]};
      it.exp  = ref_shift(m, d, 1'b0);
      sb.push_back(it);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned waited;
    waited = 0;
    while ((sb.size() != 0 || out_valid) && waited < 3000) begin
      tick();
      waited++;
    end
    if (sb.size() != 0 || out_valid) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending=%0d want 0", sb.size());
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_blk_count", blk_count, 0);
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i * 32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin : ready_gen
    forever begin
      @(posedge clock);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(1));
      endcase
    end
  end

  initial begin : monitor
    item_t            it;
    logic             held_v;
    logic [255:0]     hd;
    logic [TAG_W-1:0] ht;
    logic             hm;
    held_v = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        sb.delete();
        exp_cnt = '0;
        held_v  = 1'b0;
      end else begin
        chk("blk_count", blk_count, exp_cnt);
        if (held_v) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, hd);
          chk("stall_tag", out_tag, ht);
          chk("stall_mode", out_mode, hm);
        end
        held_v = 1'b0;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", out_valid, 0);
          end else begin
            it = sb.pop_front();
            chk("out_data", out_data, it.exp);
            chk("out_tag", out_tag, it.tag);
            chk("out_mode", out_mode, it.mode);
            chk("inverse", ref_shift(out_mode, out_data, 1'b1), it.orig);
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
          end
        end else if (out_valid) begin
          held_v = 1'b1;
          hd = out_data;
          ht = out_tag;
          hm = out_mode;
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [255:0] d;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("init_out_valid", out_valid, 0);
    chk("init_out_data", out_data, 0);
    chk("init_blk_count", blk_count, 0);
    chk("init_in_ready", in_ready, 1);
    rdy_mode = 1;
    tick();

    // Directed 128-bit vector; upper half is junk that must be ignored.
    d = rand256();
    for (int i = 0; i < 16; i++) d[(15 - i) * 8 +: 8] = 8'(i);
    send(1'b0, 4'h1, d);
    chk("vec128", out_data, {128'h0, 128'h00010203050607040A0B08090F0C0D0E});
    tick();
    chk("cnt_first", blk_count, 1);

    for (int i = 0; i < 32; i++) d[(31 - i) * 8 +: 8] = 8'(i);
    send(1'b1, 4'h2, d);
    chk("vec256", out_data,
        256'h0001020304050607_090A0B0C0D0E0F08_1314151617101112_1C1D1E1F18191A1B);
    drain();

    // Backpressure: two blocks fill the buffer, the third stalls.
    rdy_mode = 0;
    tick();
    tick();
    send(1'b0, 4'h1, rand256());
    send(1'b1, 4'h2, rand256());
    fork
      send(1'b0, 4'h3, rand256());
      begin
        repeat (3) begin
          chk("full_in_ready", in_ready, 0);
          tick();
        end
        rdy_mode = 1;
      end
    join
    drain();

    // Reset while full: held blocks must never appear.
    rdy_mode = 0;
    tick();
    tick();
    send(1'b1, 4'h5, rand256());
    send(1'b0, 4'h6, rand256());
    chk("two_in_ready", in_ready, 0);
    do_reset();
    rdy_mode = 1;
    repeat (4) begin
      tick();
      chk("post_rst_valid", out_valid, 0);
    end

    // Random mixed-mode traffic with random backpressure.
    do_reset();
    rdy_mode = 2;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(3) == 0) tick();
      send(1'($urandom_range(1)), TAG_W'($urandom), rand256());
    end
    drain();
    chk("cnt_1000", blk_count, 1000);

    // Counter saturation.
    do_reset();
    rdy_mode = 1;
    for (int n = 0; n < 65535; n++) send(1'($urandom_range(1)), TAG_W'(n), rand256());
    drain();
    chk("cnt_full", blk_count, 16'hFFFF);
    send(1'b1, 4'hA, rand256());
    drain();
    chk("cnt_sat", blk_count, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
